core_seq: RTL and testbench
===========================

// Module: core_seq
// PURPOSE
//  Instruction sequencer that drives the 37-bit inst word (and D_xmem) of the 2-D
//  weight-stationary core. For each kernel index kij it runs: weight fetch, kernel load,
//  array flush, activation fetch, execute, then ofifo drain into psum SRAM.
//  Sits between host/testbench control and the core; owns all SRAM addressing.
// PARAMETERS
//  row      8   PE rows; activation/weight vector width = bw*row
//  col      8   PE columns; weight words fetched per kij
//  bw       4   operand width (bits)
//  psum_bw  16  partial-sum width; D_xmem width = psum_bw*row
//  ADDR_W   11  SRAM address width (both SRAMs)
// PORTS
//  clk          in   1            clock
//  reset        in   1            asynchronous, active-high reset
//  start        in   1            1-cycle pulse; sampled only in IDLE
//  num_kij      in   4            kernel positions to run (0..15), latched on start
//  len_nij      in   ADDR_W       activation vectors per kij, latched on start
//  w_base       in   ADDR_W       xmem base of weights; kij k uses w_base+k*col+i
//  a_base       in   ADDR_W       xmem base of activations (same set reused every kij)
//  p_base       in   ADDR_W       psum SRAM base; output n goes to p_base+n
//  ofifo_valid  in   1            core ofifo holds a full output row
//  inst         out  37           core instruction word (field map below)
//  D_xmem       out  psum_bw*row  tied 0 (inst[35]=0 selects xmem SRAM path)
//  busy         out  1            high from cycle after accepted start until done
//  done         out  1            1-cycle pulse when sequence completes
// BEHAVIOUR
//  inst fields: [0]load [1]execute [2]l0_wr [3]l0_rd [4]ififo_rd [5]ififo_wr [6]ofifo_rd
//   [17:7]xmem A [18]xmem WEN [19]xmem CEN [30:20]pmem A [31]pmem WEN [32]pmem CEN
//   [33]acc [34]relu [35]data_sel [36]mode. [4],[5],[34],[35],[36] always 0.
//  Idle word (reset value, and every cycle in IDLE/FLUSH/wait): 37'h1_800C_0000
//   (CEN/WEN high on both SRAMs, all else 0). Reset: busy=0, done=0, all counters 0.
//  All outputs registered. SRAM read latency 1: l0_wr asserted the cycle after the
//   matching xmem read (CEN=0,WEN=1); final l0_wr occurs in the following state's 1st cycle.
//  FSM: IDLE -> WFETCH -> KLOAD -> FLUSH -> AFETCH -> EXEC -> DRAIN -> (WFETCH | FIN) -> IDLE
//   WFETCH: col cycles, xmem A=w_base+kij*col+i, then 1 tail cycle (l0_wr only).
//   KLOAD : col cycles l0_rd=1, load=1.
//   FLUSH : row+col cycles idle word (weights settle, load=0).
//   AFETCH: len_nij reads at a_base+i, l0_wr delayed 1, plus tail cycle.
//   EXEC  : len_nij cycles l0_rd=1, execute=1.
//   DRAIN : each cycle ofifo_valid=1 and n<len_nij: ofifo_rd=1, pmem CEN=0, WEN=0,
//    A=p_base+n, acc=(kij!=0); n++. Stall (idle word) while ofifo_valid=0.
//    Exit when n==len_nij; kij++; kij==num_kij -> FIN else WFETCH.
//   FIN   : done=1 one cycle, busy=0, -> IDLE.
//  Address arithmetic modulo 2^ADDR_W (wrap, no error). kij*col via shift (col pow2 req'd).
//  start while busy: ignored. num_kij==0 or len_nij==0: IDLE->FIN, no SRAM access, done next-next cycle.
//  reset mid-sequence: immediate idle word, IDLE; partial psum SRAM contents undefined.
//  Never asserts xmem and pmem write in same cycle; load and execute never both 1.
// TESTING
//  1 reset mid-EXEC -> inst==37'h1_800C_0000, busy=0 same cycle reset asserts.
//  2 num_kij=1,len_nij=4,w_base=0,a_base=64 -> xmem reads 0..7, 64..67; 4 pmem writes acc=0.
//  3 num_kij=9,len_nij=36,w_base=0 -> kij 8 weight reads at 64..71; 324 pmem writes, acc=1 for kij>=1.
//  4 ofifo_valid held 0 for 20 cycles in DRAIN -> no pmem write, n frozen; resumes on valid.
//  5 start with len_nij=0 -> done pulse, zero CEN=0 cycles; start during busy -> ignored.
//  6 p_base=2046,len_nij=4 -> pmem addresses 2046,2047,0,1.

Source files
------------

// File: rtl/core_seq.sv
// Instruction sequencer for the weight-stationary core: for each kernel index it
// fetches weights, loads them, flushes the array, streams activations, executes and drains psums.
module core_seq #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int ADDR_W  = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             num_kij,
  input  logic [ADDR_W-1:0]      len_nij,
  input  logic [ADDR_W-1:0]      w_base,
  input  logic [ADDR_W-1:0]      a_base,
  input  logic [ADDR_W-1:0]      p_base,
  input  logic                   ofifo_valid,
  output logic [36:0]            inst,
  output logic [psum_bw*row-1:0] D_xmem,
  output logic                   busy,
  output logic                   done
);

  localparam int COL_SH = $clog2(col);
  localparam logic [ADDR_W-1:0] COL_N   = ADDR_W'(col);
  localparam logic [ADDR_W-1:0] FLUSH_N = ADDR_W'(row + col);
  localparam logic [36:0] IDLE_WORD = 37'h1_800C_0000;

  localparam int B_LOAD = 0, B_EXEC = 1, B_L0WR = 2, B_L0RD = 3, B_ORD = 6;
  localparam int B_XCEN = 19, B_PWEN = 31, B_PCEN = 32, B_ACC = 33;

  if (bw < 1 || col < 1 || (col & (col - 1)) != 0) begin : g_param_chk
    $error("core_seq: col must be a power of two and bw positive");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WFETCH, S_KLOAD, S_FLUSH, S_AFETCH, S_EXEC, S_DRAIN, S_FIN
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d, n, n_d;
  logic [3:0]        kij, kij_d, nk;
  logic [ADDR_W-1:0] ln, wb, ab, pb;
  logic [ADDR_W-1:0] wb_eff;
  logic              accept, wr_d, busy_d, done_d;
  logic [36:0]       inst_d;

  assign accept = (state == S_IDLE) && start;
  // Outputs are decoded from the next state, so the first weight address must
  // come straight from the port while the base is being latched.
  assign wb_eff = (state == S_IDLE) ? w_base : wb;
  assign D_xmem = '0;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    n_d     = n;
    kij_d   = kij;
    wr_d    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          n_d   = '0;
          kij_d = '0;
          if (num_kij == '0 || len_nij == '0) begin
            state_d = S_FIN;
            cnt_d   = ADDR_W'(1);
          end else begin
            state_d = S_WFETCH;
          end
        end
      end
      S_WFETCH: begin
        if (cnt == COL_N) begin state_d = S_KLOAD; cnt_d = '0; end
        else cnt_d = cnt + 1'b1;
      end
      S_KLOAD: begin
        if (cnt == COL_N - 1'b1) begin state_d = S_FLUSH; cnt_d = '0; end
        else cnt_d = cnt + 1'b1;
      end
      S_FLUSH: begin
        if (cnt == FLUSH_N - 1'b1) begin state_d = S_AFETCH; cnt_d = '0; end
        else cnt_d = cnt + 1'b1;
      end
      S_AFETCH: begin
        if (cnt == ln) begin state_d = S_EXEC; cnt_d = '0; end
        else cnt_d = cnt + 1'b1;
      end
      S_EXEC: begin
        if (cnt == ln - 1'b1) begin state_d = S_DRAIN; cnt_d = '0; n_d = '0; end
        else cnt_d = cnt + 1'b1;
      end
      S_DRAIN: begin
        if (n == ln) begin
          cnt_d = '0;
          n_d   = '0;
          if (kij + 4'd1 == nk) state_d = S_FIN;
          else begin
            state_d = S_WFETCH;
            kij_d   = kij + 4'd1;
          end
        end else if (ofifo_valid) begin
          wr_d = 1'b1;
          n_d  = n + 1'b1;
        end
      end
      S_FIN: begin
        // cnt!=0 marks the extra busy cycle used by the empty-job path
        if (cnt != '0) cnt_d = '0;
        else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    inst_d = IDLE_WORD;
    case (state_d)
      S_WFETCH: begin
        if (cnt_d != COL_N) begin
          inst_d[B_XCEN] = 1'b0;
          inst_d[17:7]   = wb_eff + (ADDR_W'(kij_d) << COL_SH) + cnt_d;
        end
        inst_d[B_L0WR] = (cnt_d != '0);
      end
      S_KLOAD: begin
        inst_d[B_LOAD] = 1'b1;
        inst_d[B_L0RD] = 1'b1;
      end
      S_AFETCH: begin
        if (cnt_d != ln) begin
          inst_d[B_XCEN] = 1'b0;
          inst_d[17:7]   = ab + cnt_d;
        end
        inst_d[B_L0WR] = (cnt_d != '0);
      end
      S_EXEC: begin
        inst_d[B_EXEC] = 1'b1;
        inst_d[B_L0RD] = 1'b1;
      end
      S_DRAIN: begin
        if (wr_d) begin
          inst_d[B_ORD]  = 1'b1;
          inst_d[B_PCEN] = 1'b0;
          inst_d[B_PWEN] = 1'b0;
          inst_d[30:20]  = pb + n;
          inst_d[B_ACC]  = (kij != '0);
        end
      end
      default: ;
    endcase

    done_d = (state_d == S_FIN) && (cnt_d == '0);
    busy_d = (state_d != S_IDLE) && !done_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      n     <= '0;
      kij   <= '0;
      nk    <= '0;
      ln    <= '0;
      wb    <= '0;
      ab    <= '0;
      pb    <= '0;
      inst  <= IDLE_WORD;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      n     <= n_d;
      kij   <= kij_d;
      inst  <= inst_d;
      busy  <= busy_d;
      done  <= done_d;
      if (accept) begin
        nk <= num_kij;
        ln <= len_nij;
        wb <= w_base;
        ab <= a_base;
        pb <= p_base;
      end
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: a phase-level expected instruction stream checked every cycle,
// random ofifo backpressure, plus literal address/acc expectations for corner cases.
`timescale 1ns/1ps
module tb_core_seq;
  localparam int ROW = 8, COL = 8, PSUM_BW = 16, AW = 11;
  localparam logic [36:0] IDLE_W = 37'h1_800C_0000;

  logic                   clk = 1'b0;
  logic                   reset, start, ofifo_valid;
  logic [3:0]             num_kij;
  logic [AW-1:0]          len_nij, w_base, a_base, p_base;
  logic [36:0]            inst;
  logic [PSUM_BW*ROW-1:0] D_xmem;
  logic                   busy, done;

  core_seq #(.row(ROW), .col(COL), .bw(4), .psum_bw(PSUM_BW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_kij(num_kij), .len_nij(len_nij),
    .w_base(w_base), .a_base(a_base), .p_base(p_base), .ofifo_valid(ofifo_valid),
    .inst(inst), .D_xmem(D_xmem), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int stall_end = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) ofifo_valid = (cyc < stall_end) ? 1'b0 : ($urandom_range(0, 3) != 0);

  int vectors = 0, miscompares = 0;
  logic [AW-1:0] xq[$];
  logic [AW:0]   pq[$];
  int stall_idles;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [36:0] mkw(input bit ld, input bit ex, input bit l0w, input bit l0r,
                                      input bit ord, input bit xrd, input logic [AW-1:0] xa,
                                      input bit pwr, input logic [AW-1:0] pa, input bit acc);
    logic [36:0] w;
    w = '0;
    w[0] = ld; w[1] = ex; w[2] = l0w; w[3] = l0r; w[6] = ord;
    w[17:7] = xrd ? xa : '0;
    w[18] = 1'b1;
    w[19] = !xrd;
    w[30:20] = pwr ? pa : '0;
    w[31] = !pwr;
    w[32] = !pwr;
    w[33] = acc;
    return w;
  endfunction

  // Called at posedge+1; checks this cycle's outputs at the negedge.
  task automatic expect_w(input logic [36:0] w, input bit b, input bit d);
    @(negedge clk);
    vectors++;
    if (inst !== w || busy !== b || done !== d || D_xmem !== '0) begin
      miscompares++;
      $display("FAIL cycle t=%0t inst=%h want=%h busy=%b want=%b done=%b want=%b",
               $time, inst, w, busy, b, done, d);
    end
    if (inst[19] === 1'b0) xq.push_back(inst[17:7]);
    if (inst[32] === 1'b0) pq.push_back({inst[33], inst[30:20]});
    @(posedge clk); #1;
  endtask

  task automatic run(input int nk, input int ln, input logic [AW-1:0] wb,
                     input logic [AW-1:0] ab, input logic [AW-1:0] pb, input bit stall);
    int n, guard;
    bit stalled;
    xq.delete();
    pq.delete();
    stall_idles = 0;
    @(negedge clk);
    chk("idle_before_start", {inst, busy, done}, {IDLE_W, 1'b0, 1'b0});
    num_kij = 4'(nk); len_nij = AW'(ln); w_base = wb; a_base = ab; p_base = pb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (nk == 0 || ln == 0) begin
      expect_w(IDLE_W, 1, 0);
      expect_w(IDLE_W, 0, 1);
      return;
    end
    for (int k = 0; k < nk; k++) begin
      for (int i = 0; i <= COL; i++)
        expect_w(mkw(0, 0, i > 0, 0, 0, i < COL, wb + AW'(k * COL + i), 0, '0, 0), 1, 0);
      for (int i = 0; i < COL; i++) expect_w(mkw(1, 0, 0, 1, 0, 0, '0, 0, '0, 0), 1, 0);
      for (int i = 0; i < ROW + COL; i++) expect_w(IDLE_W, 1, 0);
      for (int i = 0; i <= ln; i++)
        expect_w(mkw(0, 0, i > 0, 0, 0, i < ln, ab + AW'(i), 0, '0, 0), 1, 0);
      for (int i = 0; i < ln; i++) begin
        // starts and port changes while busy must not disturb the job
        start = ($urandom_range(0, 1) == 1);
        num_kij = 4'($urandom); len_nij = AW'($urandom);
        w_base = AW'($urandom); a_base = AW'($urandom); p_base = AW'($urandom);
        expect_w(mkw(0, 1, 0, 1, 0, 0, '0, 0, '0, 0), 1, 0);
      end
      start = 1'b0;
      expect_w(IDLE_W, 1, 0);
      n = 0; guard = 0; stalled = 0;
      while (n < ln) begin
        if (stall && n == 2 && !stalled) begin
          stall_end = cyc + 21;
          stalled = 1;
        end
        if (ofifo_valid) begin
          expect_w(mkw(0, 0, 0, 0, 1, 0, '0, 1, pb + AW'(n), k != 0), 1, 0);
          n++;
        end else begin
          expect_w(IDLE_W, 1, 0);
          if (stalled) stall_idles++;
        end
        guard++;
        if (guard > 5000) begin
          $display("FAIL drain_timeout: n=%0d want %0d", n, ln);
          $fatal(1, "drain bound");
        end
      end
    end
    expect_w(IDLE_W, 0, 1);
  endtask

  initial begin
    int acc1;
    reset = 1'b1; start = 1'b0; num_kij = '0; len_nij = '0;
    w_base = '0; a_base = '0; p_base = '0;
    repeat (2) @(posedge clk); #1;
    chk("reset_inst", inst, IDLE_W);
    chk("reset_busy", 37'(busy), 37'(0));
    chk("reset_done", 37'(done), 37'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // reset while executing
    @(negedge clk);
    num_kij = 4'd1; len_nij = AW'(20); w_base = '0; a_base = AW'(64); p_base = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (56) @(posedge clk);
    #1;
    chk("mid_exec_execute", 37'(inst[1]), 37'(1));
    chk("mid_exec_busy", 37'(busy), 37'(1));
    reset = 1'b1;
    #1;
    chk("reset_async_inst", inst, IDLE_W);
    chk("reset_async_busy", 37'(busy), 37'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run(1, 4, AW'(0), AW'(64), AW'(0), 0);
    chk("t2_xreads", 37'(xq.size()), 37'(12));
    for (int i = 0; i < 8 && i < xq.size(); i++) chk("t2_wread", 37'(xq[i]), 37'(i));
    for (int i = 0; i < 4 && 8 + i < xq.size(); i++) chk("t2_aread", 37'(xq[8 + i]), 37'(64 + i));
    chk("t2_pwrites", 37'(pq.size()), 37'(4));
    for (int i = 0; i < 4 && i < pq.size(); i++) chk("t2_pwrite", 37'(pq[i]), 37'(i));

    run(9, 36, AW'(0), AW'(100), AW'(0), 0);
    chk("t3_xreads", 37'(xq.size()), 37'(9 * 44));
    for (int i = 0; i < 8 && 352 + i < xq.size(); i++) chk("t3_kij8_w", 37'(xq[352 + i]), 37'(64 + i));
    chk("t3_pwrites", 37'(pq.size()), 37'(324));
    acc1 = 0;
    foreach (pq[i]) if (pq[i][AW]) acc1++;
    chk("t3_acc_count", 37'(acc1), 37'(288));

    run(2, 6, AW'(3), AW'(200), AW'(40), 1);
    chk("t4_stall_seen", 37'(stall_idles >= 20), 37'(1));
    chk("t4_pwrites", 37'(pq.size()), 37'(12));
    for (int i = 0; i < 12 && i < pq.size(); i++)
      chk("t4_paddr", 37'(pq[i][AW-1:0]), 37'(40 + i % 6));

    run(3, 0, AW'(0), AW'(0), AW'(0), 0);
    chk("t5_len0_sram", 37'(xq.size() + pq.size()), 37'(0));
    run(0, 5, AW'(0), AW'(0), AW'(0), 0);
    chk("t5_kij0_sram", 37'(xq.size() + pq.size()), 37'(0));

    run(1, 4, AW'(5), AW'(9), AW'(2046), 0);
    chk("t6_pwrites", 37'(pq.size()), 37'(4));
    if (pq.size() == 4) begin
      chk("t6_p0", 37'(pq[0][AW-1:0]), 37'(2046));
      chk("t6_p1", 37'(pq[1][AW-1:0]), 37'(2047));
      chk("t6_p2", 37'(pq[2][AW-1:0]), 37'(0));
      chk("t6_p3", 37'(pq[3][AW-1:0]), 37'(1));
    end

    repeat (5) run($urandom_range(1, 3), $urandom_range(1, 10), AW'($urandom),
                   AW'($urandom), AW'($urandom), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
